// File: rtl/logic_gates_sweeper_if.sv
// logic_gates_sweeper_if: control, status and gate-block signals of the gate sweeper
interface logic_gates_sweeper_if #(
  parameter int ERR_W = 8
);
  logic iStart;
  logic iLoop;
  logic iAnd;
  logic iOr;
  logic iNot;
  logic oA;
  logic oB;
  logic [1:0] oVecIdx;
  logic oBusy;
  logic oDone;
  logic oPass;
  logic [ERR_W-1:0] oErrCnt;
  logic [2:0] oFailMask;
  modport master (
    output iStart, iLoop, iAnd, iOr, iNot,
    input oA, oB, oVecIdx, oBusy, oDone, oPass, oErrCnt, oFailMask
  );
  modport slave (
    input iStart, iLoop, iAnd, iOr, iNot,
    output oA, oB, oVecIdx, oBusy, oDone, oPass, oErrCnt, oFailMask
  );
endinterface

// File: rtl/logic_gates_sweeper.sv
// logic_gates_sweeper: drives all four gate input vectors, checks the gate outputs and reports errors
module logic_gates_sweeper #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W = 8
) (
  input logic iClk,
  input logic iRst_n,
  logic_gates_sweeper_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t state, stateNext;
  logic [7:0] cnt, cntNext;
  logic [1:0] idx, idxNext;
  logic [ERR_W-1:0] errCnt, errNext;
  logic [2:0] failMask, failNext, expGate, miss;
  logic pass, passNext, sample;
  // State and result registers; reset aborts any sweep and discards its results
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      errCnt <= '0;
      failMask <= '0;
      pass <= 1'b0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      idx <= idxNext;
      errCnt <= errNext;
      failMask <= failNext;
      pass <= passNext;
    end
  end
  // Next state: hold each vector, check gates on the last hold clock, then advance or finish
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    idxNext = idx;
    errNext = errCnt;
    failNext = failMask;
    passNext = pass;
    expGate = {~idx[0], idx[0] | idx[1], idx[0] & idx[1]};
    miss = {bus.iNot, bus.iOr, bus.iAnd} ^ expGate;
    sample = !(cnt < 8'(HOLD_CYCLES - 1));
    case (state)
      DRIVE: begin
        if (!sample) begin
          cntNext = cnt + 8'd1;
        end else begin
          cntNext = '0;
          idxNext = idx + 2'd1;
          errNext = (|miss && errCnt != '1) ? errCnt + ERR_W'(1) : errCnt;
          failNext = failMask | miss;
          if (idx == 2'd3 && !bus.iLoop) begin
            stateNext = DONE;
            passNext = errNext == '0;
          end
        end
      end
      default: begin
        if (bus.iStart) begin
          stateNext = DRIVE;
          cntNext = '0;
          idxNext = '0;
          errNext = '0;
          failNext = '0;
          passNext = 1'b0;
        end
      end
    endcase
  end
  assign bus.oA = idx[0];
  assign bus.oB = idx[1];
  assign bus.oVecIdx = idx;
  assign bus.oBusy = state == DRIVE;
  assign bus.oDone = state == DONE;
  assign bus.oPass = pass;
  assign bus.oErrCnt = errCnt;
  assign bus.oFailMask = failMask;
endmodule

// File: tb/tb_logic_gates_sweeper.sv
// tb_logic_gates_sweeper: directed sweeps of a faultable gate block against a behavioural model
module tb_logic_gates_sweeper;
  localparam int H = 4;
  localparam int EW = 4;
  localparam int SAT = (1 << EW) - 1;
  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  int fault = 0;
  int nAssert = 0;
  int nFail = 0;
  bit mBusy, mDone, mPass;
  int mErr, mE;
  logic [2:0] mMask;
  logic [1:0] mv;
  logic [13:0] actV, expV;
  logic_gates_sweeper_if #(.ERR_W(EW)) bus();
  logic_gates_sweeper #(.HOLD_CYCLES(H), .ERR_W(EW)) dut (.iClk(iClk), .iRst_n(iRst_n), .bus(bus));
  always #5 iClk = ~iClk;
  // Gate block: fault 1 = AND stuck at 1, fault 2 = NOT wired to B
  assign bus.iAnd = fault == 1 ? 1'b1 : bus.oA & bus.oB;
  assign bus.iOr = bus.oA | bus.oB;
  assign bus.iNot = fault == 2 ? bus.oB : ~bus.oA;
  function automatic logic [2:0] gateOut(int a, int b, int f);
    return {f == 2 ? 1'(b) : 1'(1 - a), 1'(a + b > 0), f == 1 ? 1'b1 : 1'(a * b)};
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: elapsed clocks since start decide the vector; every H-th clock samples it
  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      mBusy = 0; mDone = 0; mPass = 0; mErr = 0; mMask = '0; mE = 0;
    end else if (mBusy) begin
      int v, a, b;
      logic [2:0] got, want;
      v = (mE / H) % 4;
      a = v % 2;
      b = v / 2;
      if ((mE + 1) % H == 0) begin
        got = gateOut(a, b, fault);
        want = {1'(1 - a), 1'(a + b > 0), 1'(a * b)};
        if (got != want) mErr = mErr < SAT ? mErr + 1 : SAT;
        mMask = mMask | (got ^ want);
        if (v == 3 && !bus.iLoop) begin
          mBusy = 0; mDone = 1; mPass = mErr == 0; mE = 0;
        end else mE++;
      end else mE++;
    end else if (bus.iStart) begin
      mBusy = 1; mDone = 0; mPass = 0; mErr = 0; mMask = '0; mE = 0;
    end
  end
  assign mv = mBusy ? 2'((mE / H) % 4) : 2'd0;
  assign expV = {mv[0], mv[1], mv, mBusy, mDone, mPass, 4'(mErr), mMask};
  assign actV = {bus.oA, bus.oB, bus.oVecIdx, bus.oBusy, bus.oDone, bus.oPass, bus.oErrCnt, bus.oFailMask};
  // Every cycle: all outputs against the model
  always @(negedge iClk) check("cycle", 32'(actV), 32'(expV));
  task automatic pulseStart();
    @(negedge iClk) bus.iStart = 1'b1;
    @(negedge iClk) bus.iStart = 1'b0;
  endtask
  initial begin
    bus.iStart = 1'b0;
    bus.iLoop = 1'b0;
    pulseStart();
    check("rstHold", 32'(actV), 32'd0);
    @(posedge iClk) #3 iRst_n = 1'b1;
    repeat (3) @(negedge iClk);
    check("postRelease", 32'(actV), 32'd0);
    pulseStart();
    check("firstVec", {bus.oBusy, bus.oVecIdx}, 3'b100);
    repeat (4) @(negedge iClk);
    check("secondVec", {bus.oA, bus.oB, bus.oVecIdx}, 4'b1001);
    repeat (12) @(negedge iClk);
    check("cleanDone", {bus.oDone, bus.oBusy, bus.oPass, bus.oErrCnt, bus.oFailMask}, 10'b1_0_1_0000_000);
    fault = 1;
    pulseStart();
    repeat (16) @(negedge iClk);
    check("andStuck", {bus.oDone, bus.oPass, bus.oErrCnt, bus.oFailMask}, 9'b1_0_0011_001);
    fault = 2;
    pulseStart();
    repeat (16) @(negedge iClk);
    check("notIsB", {bus.oDone, bus.oPass, bus.oErrCnt, bus.oFailMask}, 9'b1_0_0010_100);
    pulseStart();
    check("restartClear", {bus.oBusy, bus.oDone, bus.oErrCnt, bus.oFailMask}, 9'b1_0_0000_000);
    repeat (16) @(negedge iClk);
    fault = 1;
    bus.iLoop = 1'b1;
    pulseStart();
    repeat (78) @(negedge iClk);
    pulseStart();
    check("satAt5", {bus.oBusy, bus.oErrCnt}, 5'b1_1111);
    repeat (8) @(negedge iClk);
    bus.iLoop = 1'b0;
    repeat (8) @(negedge iClk);
    check("loopDone", {bus.oDone, bus.oPass, bus.oErrCnt, bus.oFailMask}, 9'b1_0_1111_001);
    fault = 0;
    pulseStart();
    repeat (8) @(negedge iClk);
    check("midIdx", 32'(bus.oVecIdx), 32'd2);
    @(posedge iClk) #2 iRst_n = 1'b0;
    #1 check("asyncRst", 32'(actV), 32'd0);
    @(posedge iClk) #3 iRst_n = 1'b1;
    pulseStart();
    check("afterRstIdx", {bus.oBusy, bus.oVecIdx}, 3'b100);
    repeat (16) @(negedge iClk);
    check("afterRstDone", {bus.oDone, bus.oPass, bus.oErrCnt, bus.oFailMask}, 9'b1_1_0000_000);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
